// File: rtl/yn_capture.sv
// yn_capture: output-side capture buffer for the PDA FIR datapath.
//
// Samples Yn on each sample_en strobe once armed. It discards the first SKIP
// strobes and then stores DEPTH samples into an internal buffer. While it
// stores, it keeps the signed maximum and minimum of the stored samples. The
// buffer can be read back through a two-edge-latency read port while idle or
// done.
//
// Ports:
//   clk        rising-edge system clock
//   Rst        synchronous active-high reset
//   Yn         signed filter output sample
//   sample_en  one-cycle strobe qualifying Yn
//   arm        one-cycle request to start a new record (IDLE/DONE only)
//   busy       high while skipping or capturing
//   done       high once a full record is stored, until next arm/reset
//   cap_count  samples stored in the current record (saturates at DEPTH)
//   peak_max   signed maximum of stored samples
//   peak_min   signed minimum of stored samples
//   rd_en      read request (honoured in IDLE/DONE only)
//   rd_addr    read address; addresses >= DEPTH read as zero
//   rd_data    read data
//   rd_valid   one-cycle pulse qualifying rd_data
module yn_capture #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DEPTH  = 177,
    parameter int unsigned SKIP   = 2
) (
    input  logic              clk,
    input  logic              Rst,
    input  logic [DATA_W-1:0] Yn,
    input  logic              sample_en,
    input  logic              arm,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   cap_count,
    output logic [DATA_W-1:0] peak_max,
    output logic [DATA_W-1:0] peak_min,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid
);

    typedef enum logic [1:0] {StIdle, StSkip, StCapture, StDone} state_e;

    localparam int unsigned CNT_W  = ADDR_W + 1;
    localparam int unsigned SKIP_W = (SKIP > 1) ? $clog2(SKIP) : 1;

    localparam logic [CNT_W-1:0]  LastIdx   = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  DepthC    = CNT_W'(DEPTH);
    localparam logic [SKIP_W-1:0] SkipLast  = SKIP_W'((SKIP > 0) ? SKIP - 1 : 0);
    localparam logic [DATA_W-1:0] MostNeg   = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] MostPos   = ~MostNeg;
    localparam state_e            ArmTarget = (SKIP > 0) ? StSkip : StCapture;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cap_count_q, cap_count_d;
    logic [SKIP_W-1:0]   skip_cnt_q, skip_cnt_d;
    logic [DATA_W-1:0]   peak_max_q, peak_max_d;
    logic [DATA_W-1:0]   peak_min_q, peak_min_d;
    logic                wr_en;

    logic [DATA_W-1:0]   mem_q [DEPTH];

    // Read pipeline: stage 1 captures the word at the request edge, stage 2 presents it.
    logic                rd_accept;
    logic                rd_in_range;
    logic                rd_pend_q;
    logic [DATA_W-1:0]   rd_stage_q;
    logic [DATA_W-1:0]   rd_data_q;
    logic                rd_valid_q;

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cap_count_d = cap_count_q;
        skip_cnt_d  = skip_cnt_q;
        peak_max_d  = peak_max_q;
        peak_min_d  = peak_min_q;
        wr_en       = 1'b0;

        unique case (state_q)
            StIdle, StDone: begin
                if (arm) begin
                    state_d     = ArmTarget;
                    cap_count_d = '0;
                    skip_cnt_d  = '0;
                    peak_max_d  = MostNeg;
                    peak_min_d  = MostPos;
                end
            end
            StSkip: begin
                if (sample_en) begin
                    skip_cnt_d = skip_cnt_q + SKIP_W'(1);
                    if (skip_cnt_q == SkipLast) begin
                        state_d = StCapture;
                    end
                end
            end
            StCapture: begin
                if (sample_en) begin
                    wr_en       = 1'b1;
                    cap_count_d = cap_count_q + CNT_W'(1);
                    // Strict compares: a sample equal to a peak leaves it untouched.
                    if ($signed(Yn) > $signed(peak_max_q)) begin
                        peak_max_d = Yn;
                    end
                    if ($signed(Yn) < $signed(peak_min_q)) begin
                        peak_min_d = Yn;
                    end
                    if (cap_count_q == LastIdx) begin
                        state_d = StDone;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (Rst) begin
            state_q     <= StIdle;
            cap_count_q <= '0;
            skip_cnt_q  <= '0;
            peak_max_q  <= MostNeg;
            peak_min_q  <= MostPos;
        end else begin
            state_q     <= state_d;
            cap_count_q <= cap_count_d;
            skip_cnt_q  <= skip_cnt_d;
            peak_max_q  <= peak_max_d;
            peak_min_q  <= peak_min_d;
        end
    end

    // Buffer storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[cap_count_q[ADDR_W-1:0]] <= Yn;
        end
    end

    // ---------------------------------------------------------------------
    // Read port
    // ---------------------------------------------------------------------
    assign rd_accept   = rd_en && ((state_q == StIdle) || (state_q == StDone));
    assign rd_in_range = ({1'b0, rd_addr} < DepthC);

    // The word is taken at the request edge, so a same-cycle arm cannot
    // affect it: the earliest possible write lands on a later edge.
    always_ff @(posedge clk) begin
        if (Rst) begin
            rd_pend_q  <= 1'b0;
            rd_stage_q <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_pend_q  <= rd_accept;
            if (rd_accept) begin
                rd_stage_q <= rd_in_range ? mem_q[rd_addr] : '0;
            end
            rd_valid_q <= rd_pend_q;
            if (rd_pend_q) begin
                rd_data_q <= rd_stage_q;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign busy      = (state_q == StSkip) || (state_q == StCapture);
    assign done      = (state_q == StDone);
    assign cap_count = cap_count_q;
    assign peak_max  = peak_max_q;
    assign peak_min  = peak_min_q;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;

endmodule

// File: tb/tb_yn_capture.sv
// tb_yn_capture: directed + randomized bench for yn_capture.
//
// A record-level model tracks strobes since arming, the stored samples and
// the resulting count/done/peaks/read data. All checks are immediate
// assertions made 1 time unit after a rising edge.
module tb_yn_capture;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 177;
    localparam int SKIP   = 2;

    logic              clk = 1'b0;
    logic              Rst;
    logic [DATA_W-1:0] Yn;
    logic              sample_en;
    logic              arm;
    logic              busy;
    logic              done;
    logic [ADDR_W:0]   cap_count;
    logic [DATA_W-1:0] peak_max;
    logic [DATA_W-1:0] peak_min;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;

    always #5 clk = ~clk;

    yn_capture #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .SKIP   (SKIP)
    ) dut (
        .clk       (clk),
        .Rst       (Rst),
        .Yn        (Yn),
        .sample_en (sample_en),
        .arm       (arm),
        .busy      (busy),
        .done      (done),
        .cap_count (cap_count),
        .peak_max  (peak_max),
        .peak_min  (peak_min),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid)
    );

    int checks   = 0;
    int failures = 0;

    // ---------------- reference model ----------------
    logic [15:0] m_mem [256];
    bit          m_armed   = 1'b0;
    int          m_strobes = 0;

    function automatic int exp_cap();
        if (!m_armed || m_strobes <= SKIP) return 0;
        return (m_strobes - SKIP > DEPTH) ? DEPTH : m_strobes - SKIP;
    endfunction

    function automatic bit exp_done();
        return m_armed && (m_strobes >= SKIP + DEPTH);
    endfunction

    function automatic bit exp_busy();
        return m_armed && !exp_done();
    endfunction

    function automatic int exp_max();
        int mx = -32768;
        for (int i = 0; i < exp_cap(); i++) begin
            int v = $signed(m_mem[i]);
            if (v > mx) mx = v;
        end
        return mx;
    endfunction

    function automatic int exp_min();
        int mn = 32767;
        for (int i = 0; i < exp_cap(); i++) begin
            int v = $signed(m_mem[i]);
            if (v < mn) mn = v;
        end
        return mn;
    endfunction

    function automatic logic [31:0] exp_rd(int a);
        return (a < DEPTH) ? {16'h0, m_mem[a]} : 32'h0;
    endfunction

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".busy"}, 32'(busy), 32'(exp_busy()));
        chk({tag, ".done"}, 32'(done), 32'(exp_done()));
        chk({tag, ".cap_count"}, 32'(cap_count), 32'(exp_cap()));
        chk({tag, ".peak_max"}, 32'($signed(peak_max)), 32'(exp_max()));
        chk({tag, ".peak_min"}, 32'($signed(peak_min)), 32'(exp_min()));
    endtask

    task automatic do_reset(input int n);
        Rst = 1'b1;
        repeat (n) tick();
        Rst = 1'b0;
        m_armed   = 1'b0;
        m_strobes = 0;
    endtask

    task automatic do_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
        if (!exp_busy()) begin
            m_armed   = 1'b1;
            m_strobes = 0;
        end
    endtask

    task automatic strobe(input logic [15:0] v, input int gap);
        Yn        = v;
        sample_en = 1'b1;
        tick();
        sample_en = 1'b0;
        Yn        = 16'($urandom);
        if (exp_busy()) begin
            if (m_strobes >= SKIP) m_mem[m_strobes - SKIP] = v;
            m_strobes++;
        end
        check_state("strobe");
        repeat (gap) tick();
    endtask

    // Back-to-back reads; each response is checked one edge after its request edge.
    task automatic read_seq(input int addrs[$], input string tag);
        int n = addrs.size();
        for (int i = 0; i <= n; i++) begin
            if (i < n) begin
                rd_en   = 1'b1;
                rd_addr = 8'(addrs[i]);
            end else begin
                rd_en = 1'b0;
            end
            tick();
            if (i == 0) begin
                chk({tag, ".rd_valid_first"}, 32'(rd_valid), 32'd0);
            end else begin
                chk({tag, ".rd_valid"}, 32'(rd_valid), 32'd1);
                chk({tag, ".rd_data"}, 32'(rd_data), exp_rd(addrs[i-1]));
            end
        end
        tick();
        chk({tag, ".rd_valid_end"}, 32'(rd_valid), 32'd0);
    endtask

    initial begin
        int q[$];
        logic [15:0] saved;
        logic [15:0] v;

        Rst = 1'b0; Yn = '0; sample_en = 1'b0; arm = 1'b0; rd_en = 1'b0; rd_addr = '0;

        // Reset
        do_reset(3);
        check_state("reset");
        chk("reset.rd_valid", 32'(rd_valid), 32'd0);
        chk("reset.rd_data", 32'(rd_data), 32'd0);
        chk("reset.peak_max_raw", 32'(peak_max), 32'h8000);
        chk("reset.peak_min_raw", 32'(peak_min), 32'h7fff);

        // Skip then ramp, one strobe every 5 cycles
        do_arm();
        check_state("arm1");
        for (int k = 0; k < 179; k++) strobe(16'(100 + k), 4);
        chk("ramp.done", 32'(done), 32'd1);
        chk("ramp.cap_count", 32'(cap_count), 32'd177);
        chk("ramp.model_buf0", 32'(m_mem[0]), 32'd102);
        chk("ramp.model_buf176", 32'(m_mem[176]), 32'd278);
        q = '{0, 176, 1, 200};
        read_seq(q, "ramp_rd");
        // Strobes while done are ignored
        for (int k = 0; k < 3; k++) strobe(16'($urandom), 0);

        // Signed peaks with extreme values and repeated 0x7FFF
        do_arm();
        check_state("arm2");
        strobe(16'($urandom), 1);
        strobe(16'($urandom), 0);
        for (int i = 0; i < DEPTH; i++) begin
            v = 16'($urandom);
            if (i == 3) v = 16'h8000;
            if (i == 10) v = 16'h7fff;
            if (i == 11) v = 16'hfffb;
            if (i % 20 == 15) v = 16'h7fff;
            strobe(v, $urandom_range(0, 2));
        end
        chk("peaks.max", 32'($signed(peak_max)), 32'(32767));
        chk("peaks.min", 32'($signed(peak_min)), 32'(-32768));

        // Readback in DONE
        q = '{0, 1, 2, 200};
        read_seq(q, "done_rd");

        // Read and arm in the same cycle: read returns pre-arm contents
        saved   = m_mem[5];
        rd_en   = 1'b1;
        rd_addr = 8'd5;
        arm     = 1'b1;
        tick();
        rd_en = 1'b0;
        arm   = 1'b0;
        m_armed   = 1'b1;
        m_strobes = 0;
        check_state("arm_rd");
        tick();
        chk("arm_rd.rd_valid", 32'(rd_valid), 32'd1);
        chk("arm_rd.rd_data", 32'(rd_data), 32'(saved));

        // Ignored arm/read during capture at cap_count=50
        while (exp_cap() < 50) strobe(16'($urandom), $urandom_range(0, 2));
        saved   = rd_data;
        arm     = 1'b1;
        rd_en   = 1'b1;
        rd_addr = 8'd0;
        tick();
        arm   = 1'b0;
        rd_en = 1'b0;
        check_state("ign");
        tick();
        chk("ign.rd_valid1", 32'(rd_valid), 32'd0);
        chk("ign.rd_data1", 32'(rd_data), 32'(saved));
        tick();
        chk("ign.rd_valid2", 32'(rd_valid), 32'd0);
        while (!exp_done()) strobe(16'($urandom), $urandom_range(0, 1));
        chk("ign.cap_count", 32'(cap_count), 32'd177);
        q = '{50, 51, 176, 177, 255};
        read_seq(q, "ign_rd");

        // Reset mid-capture at cap_count=90, then a fresh full record
        do_arm();
        while (exp_cap() < 90) strobe(16'($urandom), $urandom_range(0, 1));
        do_reset(1);
        check_state("midrst");
        chk("midrst.rd_valid", 32'(rd_valid), 32'd0);
        do_arm();
        while (!exp_done()) strobe(16'($urandom), $urandom_range(0, 1));
        chk("rearm.cap_count", 32'(cap_count), 32'd177);
        q = '{};
        for (int i = 0; i < 6; i++) q.push_back($urandom_range(0, 255));
        read_seq(q, "rearm_rd");

        // Reset drops an in-flight read
        rd_en   = 1'b1;
        rd_addr = 8'd3;
        tick();
        rd_en = 1'b0;
        Rst   = 1'b1;
        tick();
        Rst = 1'b0;
        m_armed   = 1'b0;
        m_strobes = 0;
        chk("inflight.rd_valid", 32'(rd_valid), 32'd0);
        chk("inflight.rd_data", 32'(rd_data), 32'd0);
        check_state("inflight");
        tick();
        chk("inflight.rd_valid2", 32'(rd_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
